// File: rtl/branch_resolve_queue.sv
// In-order prediction queue between the gshare predictor and branch execute; BRQ_STATS_EN adds resolve/mispredict counters.
// Latency: train_* registered, valid 1 cycle after resolve_valid. Backpressure: predict_ready = !full; a mispredict flushes all younger entries.
module branch_resolve_queue #(
    parameter int PC_W   = 7,
    parameter int HIST_W = 7,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       predict_valid,
    input  logic [PC_W-1:0]            predict_pc,
    input  logic                       predict_taken,
    input  logic [HIST_W-1:0]          predict_history,
    output logic                       predict_ready,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    output logic                       train_valid,
    output logic                       train_taken,
    output logic                       train_mispredicted,
    output logic [HIST_W-1:0]          train_history,
    output logic [PC_W-1:0]            train_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
`ifdef BRQ_STATS_EN
    ,
    output logic [15:0]                stat_resolved,
    output logic [15:0]                stat_mispred
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              taken;
        logic [HIST_W-1:0] history;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   cnt;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               mispredict;
    entry_t             head_ent;
    logic [PTR_W-1:0]   head_inc;

    always_comb begin
        full       = (cnt == CNT_W'(DEPTH));
        empty      = (cnt == '0);
        head_ent   = mem[head];
        head_inc   = head + PTR_W'(1);
        pop        = resolve_valid && !empty;
        mispredict = pop && (resolve_taken ^ head_ent.taken);
        // Pushes arriving alongside a mispredict are on the wrong path.
        push       = predict_valid && !full && !mispredict;
    end

    assign predict_ready = !full;
    assign count         = cnt;

    // Storage carries no reset: validity is tracked solely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{pc: predict_pc, taken: predict_taken, history: predict_history};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (mispredict) begin
            head <= head_inc;
            tail <= head_inc;
            cnt  <= '0;
        end else begin
            if (pop) begin
                head <= head_inc;
            end
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            train_valid        <= 1'b0;
            train_taken        <= 1'b0;
            train_mispredicted <= 1'b0;
            train_history      <= '0;
            train_pc           <= '0;
        end else begin
            train_valid <= pop;
            if (pop) begin
                train_taken        <= resolve_taken;
                train_mispredicted <= resolve_taken ^ head_ent.taken;
                train_history      <= head_ent.history;
                train_pc           <= head_ent.pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((predict_valid && full) || (resolve_valid && empty)) begin
            err <= 1'b1;
        end
    end

`ifdef BRQ_STATS_EN
    // Counters follow the emitted training strobe, so they lag train_valid by a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_resolved <= '0;
            stat_mispred  <= '0;
        end else begin
            if (train_valid && stat_resolved != 16'hFFFF) begin
                stat_resolved <= stat_resolved + 16'd1;
            end
            if (train_valid && train_mispredicted && stat_mispred != 16'hFFFF) begin
                stat_mispred <= stat_mispred + 16'd1;
            end
        end
    end
`else
    // Statistics counters not built.
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue against a queue-based reference model.
module tb_branch_resolve_queue;

    localparam int PC_W   = 7;
    localparam int HIST_W = 7;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst;
    logic              predict_valid;
    logic [PC_W-1:0]   predict_pc;
    logic              predict_taken;
    logic [HIST_W-1:0] predict_history;
    logic              predict_ready;
    logic              resolve_valid;
    logic              resolve_taken;
    logic              train_valid;
    logic              train_taken;
    logic              train_mispredicted;
    logic [HIST_W-1:0] train_history;
    logic [PC_W-1:0]   train_pc;
    logic [$clog2(DEPTH):0] count;
    logic              err;
`ifdef BRQ_STATS_EN
    logic [15:0]       stat_resolved;
    logic [15:0]       stat_mispred;
`endif

    branch_resolve_queue #(.PC_W(PC_W), .HIST_W(HIST_W), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .predict_valid      (predict_valid),
        .predict_pc         (predict_pc),
        .predict_taken      (predict_taken),
        .predict_history    (predict_history),
        .predict_ready      (predict_ready),
        .resolve_valid      (resolve_valid),
        .resolve_taken      (resolve_taken),
        .train_valid        (train_valid),
        .train_taken        (train_taken),
        .train_mispredicted (train_mispredicted),
        .train_history      (train_history),
        .train_pc           (train_pc),
        .count              (count),
        .err                (err)
`ifdef BRQ_STATS_EN
        ,
        .stat_resolved      (stat_resolved),
        .stat_mispred       (stat_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic              taken;
        logic [HIST_W-1:0] hist;
    } ent_t;

    ent_t              q[$];
    logic              m_err;
    logic              m_tv;
    logic              m_tt;
    logic              m_tmis;
    logic [PC_W-1:0]   m_tpc;
    logic [HIST_W-1:0] m_thist;
    int                m_stat_r;
    int                m_stat_m;

    int vectors;
    int miscompares;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("count", 32'(count), 32'(q.size()));
        check_val("predict_ready", 32'(predict_ready), 32'(q.size() != DEPTH));
        check_val("err", 32'(err), 32'(m_err));
        check_val("train_valid", 32'(train_valid), 32'(m_tv));
        if (m_tv) begin
            check_val("train_pc", 32'(train_pc), 32'(m_tpc));
            check_val("train_history", 32'(train_history), 32'(m_thist));
            check_val("train_taken", 32'(train_taken), 32'(m_tt));
            check_val("train_mispredicted", 32'(train_mispredicted), 32'(m_tmis));
        end
`ifdef BRQ_STATS_EN
        check_val("stat_resolved", 32'(stat_resolved), 32'(m_stat_r));
        check_val("stat_mispred", 32'(stat_mispred), 32'(m_stat_m));
`endif
    endtask

    // Called at a falling edge; applies one cycle of stimulus and checks the result.
    task automatic step(input logic pv, input logic [PC_W-1:0] pc, input logic pt,
                        input logic [HIST_W-1:0] ph, input logic rv, input logic rt);
        ent_t e;
        bit   full;
        predict_valid   = pv;
        predict_pc      = pc;
        predict_taken   = pt;
        predict_history = ph;
        resolve_valid   = rv;
        resolve_taken   = rt;

        if (m_tv && m_stat_r < 16'hFFFF) m_stat_r++;
        if (m_tv && m_tmis && m_stat_m < 16'hFFFF) m_stat_m++;
        full = (q.size() == DEPTH);
        if (pv && full) m_err = 1'b1;
        if (rv && q.size() == 0) m_err = 1'b1;
        m_tv   = 1'b0;
        m_tmis = 1'b0;
        if (rv && q.size() != 0) begin
            e       = q.pop_front();
            m_tv    = 1'b1;
            m_tpc   = e.pc;
            m_thist = e.hist;
            m_tt    = rt;
            m_tmis  = rt ^ e.taken;
            if (m_tmis) q.delete();
        end
        if (pv && !full && !m_tmis) q.push_back('{pc, pt, ph});

        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        predict_valid   = 1'b0;
        predict_pc      = '0;
        predict_taken   = 1'b0;
        predict_history = '0;
        resolve_valid   = 1'b0;
        resolve_taken   = 1'b0;
    endtask

    // Reset asserted between edges to exercise the asynchronous path.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        idle_inputs();
        q.delete();
        m_err = 0; m_tv = 0; m_tt = 0; m_tmis = 0; m_tpc = '0; m_thist = '0;
        m_stat_r = 0; m_stat_m = 0;
        #1;
        check_val("rst_async_count", 32'(count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_all();
        check_val("rst_train_pc", 32'(train_pc), 32'd0);
        check_val("rst_train_hist", 32'(train_history), 32'd0);
        check_val("rst_train_taken", 32'(train_taken), 32'd0);
        check_val("rst_train_mis", 32'(train_mispredicted), 32'd0);
        rst = 1'b0;
    endtask

    task automatic push(input logic [PC_W-1:0] pc, input logic pt, input logic [HIST_W-1:0] ph);
        step(1'b1, pc, pt, ph, 1'b0, 1'b0);
    endtask

    initial begin
        logic rt;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle_inputs();
        @(negedge clk);
        do_reset();

        // Reset mid-stream with entries queued.
        push(7'h11, 1'b1, 7'h01);
        push(7'h12, 1'b0, 7'h02);
        push(7'h13, 1'b1, 7'h03);
        check_val("t1_count_before", 32'(count), 32'd3);
        do_reset();
        check_val("t1_ready", 32'(predict_ready), 32'd1);

        // Single correct resolution.
        push(7'h05, 1'b1, 7'h2A);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        check_val("t2_valid", 32'(train_valid), 32'd1);
        check_val("t2_pc", 32'(train_pc), 32'h05);
        check_val("t2_hist", 32'(train_history), 32'h2A);
        check_val("t2_taken", 32'(train_taken), 32'd1);
        check_val("t2_mis", 32'(train_mispredicted), 32'd0);
        @(negedge clk);
        check_val("t2_pulse", 32'(train_valid), 32'd0);

        // Fill, overflow, drain in order.
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(7'(8'h40 + i), 1'(i % 2), 7'(i * 3));
        check_val("t3_full_count", 32'(count), 32'd8);
        check_val("t3_ready", 32'(predict_ready), 32'd0);
        push(7'h7F, 1'b1, 7'h7F);
        check_val("t3_err", 32'(err), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b0, '0, 1'b1, 1'(i % 2));
            check_val("t3_order", 32'(train_pc), 32'(8'h40 + i));
        end
        check_val("t3_empty", 32'(count), 32'd0);

        // Mispredict flush with a concurrent push.
        do_reset();
        push(7'h21, 1'b0, 7'h10);
        push(7'h22, 1'b1, 7'h11);
        push(7'h23, 1'b1, 7'h12);
        push(7'h24, 1'b0, 7'h13);
        step(1'b1, 7'h55, 1'b1, 7'h55, 1'b1, 1'b1);
        check_val("t4_mis", 32'(train_mispredicted), 32'd1);
        check_val("t4_count", 32'(count), 32'd0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        check_val("t4_push_dropped", 32'(train_valid), 32'd0);

        // Resolve on empty.
        do_reset();
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        check_val("t5_no_train", 32'(train_valid), 32'd0);
        check_val("t5_err", 32'(err), 32'd1);

        // Pointer wrap with steady occupancy.
        do_reset();
        for (int i = 0; i < 6; i++) push(7'(i), 1'b1, 7'(i));
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 7'(8'h30 + i), 1'b0, 7'(i), 1'b1, 1'b1);
            check_val("t6_steady", 32'(count), 32'd6);
        end
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        check_val("t6_drained", 32'(count), 32'd0);

        // Randomized traffic with periodic resets.
        for (int n = 0; n < 1200; n++) begin
            if (n % 200 == 199) do_reset();
            if (q.size() != 0)
                rt = ($urandom_range(4) != 0) ? q[0].taken : !q[0].taken;
            else
                rt = 1'($urandom);
            step(($urandom_range(9) < 6), 7'($urandom), 1'($urandom), 7'($urandom),
                 ($urandom_range(9) < 5), rt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
